// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RISC-V sequencer:
// opcodes, state encoding and datapath mux-select encodings.
package rv_ctrl_pkg;

  localparam int OPC_W   = 7;
  localparam int STATE_W = 4;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I_ALU  = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR_TGT = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLD_PC = 2'b01, SRCA_RS1 = 2'b10} src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} src_b_e;
  typedef enum logic [1:0] {OPC_ADD = 2'b00, OPC_SUB = 2'b01, OPC_FUNCT = 2'b10} op_class_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} result_sel_e;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Shared instruction/data memory port handshake between sequencer and memory.
interface mc_ctrl_fsm_if;
  logic o_mem_req;
  logic o_mem_wr_en;
  logic o_adr_src;
  logic i_mem_ready;

  modport master (output o_mem_req, output o_mem_wr_en, output o_adr_src, input i_mem_ready);
  modport slave  (input o_mem_req, input o_mem_wr_en, input o_adr_src, output i_mem_ready);
endinterface

// File: rtl/mc_ctrl_next_state.sv
// Combinational next-state logic of the multi-cycle sequencer.
module mc_ctrl_next_state
  import rv_ctrl_pkg::*;
#(
  parameter int OP_CODE_WIDTH = 7
) (
  input  state_e                   state,
  input  logic [OP_CODE_WIDTH-1:0] op_code,
  input  logic                     mem_ready,
  output state_e                   next_state
);

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_code == OP_CODE_WIDTH'(OP_LOAD) || op_code == OP_CODE_WIDTH'(OP_STORE))
          next_state = S_MEMADR;
        else if (op_code == OP_CODE_WIDTH'(OP_R))      next_state = S_EXEC_R;
        else if (op_code == OP_CODE_WIDTH'(OP_I_ALU))  next_state = S_EXEC_I;
        else if (op_code == OP_CODE_WIDTH'(OP_BRANCH)) next_state = S_BRANCH;
        else if (op_code == OP_CODE_WIDTH'(OP_JAL))    next_state = S_JUMP;
        else if (op_code == OP_CODE_WIDTH'(OP_JALR))   next_state = S_JALR_TGT;
        else                                           next_state = S_TRAP;
      end
      S_MEMADR:   next_state = (op_code == OP_CODE_WIDTH'(OP_LOAD)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R:   next_state = S_ALUWB;
      S_EXEC_I:   next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_ALUWB;
      S_JALR_TGT: next_state = S_JUMP;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main sequencer for the multi-cycle RISC-V datapath; MC_CTRL_INSTRET_EN
// builds the retired-instruction counter, otherwise o_instret is 0.
//
// state    | meaning
// FETCH    | read instruction, load IR and PC+4
// DECODE   | branch/JAL target into ALUOut, dispatch on opcode
// MEMADR   | compute load/store address
// MEMRD    | data read
// MEMWB    | write load data to register file
// MEMWR    | data write
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// ALUWB    | write ALUOut to register file
// BRANCH   | compare, take branch on zero
// JUMP     | load PC from ALUOut, compute link value
// JALR_TGT | compute rs1+imm target
// TRAP     | unsupported opcode, parked until reset
module mc_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int OP_CODE_WIDTH = 7,
  parameter int STATE_WIDTH   = 4,
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [OP_CODE_WIDTH-1:0] i_op_code,
  input  logic                     i_alu_zero_flag,
  mc_ctrl_fsm_if.master            mem,
  output logic                     o_ir_wr_en,
  output logic                     o_pc_wr_en,
  output logic [1:0]               o_alu_src_a,
  output logic [1:0]               o_alu_src_b,
  output logic [1:0]               o_alu_op_class,
  output logic [1:0]               o_result_sel,
  output logic                     o_reg_file_wr_en,
  output logic                     o_illegal_instr,
  output logic [STATE_WIDTH-1:0]   o_state,
  output logic [INSTRET_WIDTH-1:0] o_instret
);

  state_e      state, next_state;
  logic        illegal;
  logic        req, wr, adr, ir_wr, pc_wr, rf_wr;
  src_a_e      src_a;
  src_b_e      src_b;
  op_class_e   op_class;
  result_sel_e res_sel;

  mc_ctrl_next_state #(.OP_CODE_WIDTH(OP_CODE_WIDTH)) u_next (
    .state      (state),
    .op_code    (i_op_code),
    .mem_ready  (mem.i_mem_ready),
    .next_state (next_state)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP) illegal <= 1'b1;
    end
  end

  always_comb begin
    req = 1'b0; wr = 1'b0; adr = 1'b0; ir_wr = 1'b0; pc_wr = 1'b0; rf_wr = 1'b0;
    src_a = SRCA_PC; src_b = SRCB_RS2; op_class = OPC_ADD; res_sel = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        req = 1'b1; src_b = SRCB_FOUR; res_sel = RES_ALU;
        ir_wr = mem.i_mem_ready;
        pc_wr = mem.i_mem_ready;
      end
      S_DECODE:   begin src_a = SRCA_OLD_PC; src_b = SRCB_IMM; end
      S_MEMADR:   begin src_a = SRCA_RS1; src_b = SRCB_IMM; end
      S_MEMRD:    begin req = 1'b1; adr = 1'b1; end
      S_MEMWB:    begin res_sel = RES_MEM; rf_wr = 1'b1; end
      S_MEMWR:    begin req = 1'b1; wr = 1'b1; adr = 1'b1; end
      S_EXEC_R:   begin src_a = SRCA_RS1; op_class = OPC_FUNCT; end
      S_EXEC_I:   begin src_a = SRCA_RS1; src_b = SRCB_IMM; op_class = OPC_FUNCT; end
      S_ALUWB:    rf_wr = 1'b1;
      S_BRANCH:   begin src_a = SRCA_RS1; op_class = OPC_SUB; pc_wr = i_alu_zero_flag; end
      S_JUMP:     begin pc_wr = 1'b1; src_a = SRCA_OLD_PC; src_b = SRCB_FOUR; end
      S_JALR_TGT: begin src_a = SRCA_RS1; src_b = SRCB_IMM; end
      default: ;
    endcase
    // Reset abandons any transfer in flight: nothing may be requested or written.
    if (i_reset) begin
      req = 1'b0; wr = 1'b0; adr = 1'b0; ir_wr = 1'b0; pc_wr = 1'b0; rf_wr = 1'b0;
      src_a = SRCA_PC; src_b = SRCB_RS2; op_class = OPC_ADD; res_sel = RES_ALUOUT;
    end
  end

  assign mem.o_mem_req    = req;
  assign mem.o_mem_wr_en  = wr;
  assign mem.o_adr_src    = adr;
  assign o_ir_wr_en       = ir_wr;
  assign o_pc_wr_en       = pc_wr;
  assign o_alu_src_a      = src_a;
  assign o_alu_src_b      = src_b;
  assign o_alu_op_class   = op_class;
  assign o_result_sel     = res_sel;
  assign o_reg_file_wr_en = rf_wr;
  assign o_illegal_instr  = illegal;
  assign o_state          = STATE_WIDTH'(state);

`ifdef MC_CTRL_INSTRET_EN
  logic                     retire;
  logic [INSTRET_WIDTH-1:0] instret;

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                  ((state == S_MEMWR) && mem.i_mem_ready);

  always_ff @(posedge i_clk) begin
    if (i_reset)     instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end

  assign o_instret = instret;
`else
  assign o_instret = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed scenarios plus randomized
// instruction streams compared against a per-instruction phase model.
module tb_mc_ctrl_fsm;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [6:0]  i_op_code = 7'd0;
  logic        i_alu_zero_flag = 1'b0;
  logic        o_ir_wr_en, o_pc_wr_en, o_reg_file_wr_en, o_illegal_instr;
  logic [1:0]  o_alu_src_a, o_alu_src_b, o_alu_op_class, o_result_sel;
  logic [3:0]  o_state;
  logic [31:0] o_instret;

  int errors = 0;
  int checks = 0;
  logic [31:0] retired = 0;

  mc_ctrl_fsm_if mif ();

  mc_ctrl_fsm dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_op_code        (i_op_code),
    .i_alu_zero_flag  (i_alu_zero_flag),
    .mem              (mif.master),
    .o_ir_wr_en       (o_ir_wr_en),
    .o_pc_wr_en       (o_pc_wr_en),
    .o_alu_src_a      (o_alu_src_a),
    .o_alu_src_b      (o_alu_src_b),
    .o_alu_op_class   (o_alu_op_class),
    .o_result_sel     (o_result_sel),
    .o_reg_file_wr_en (o_reg_file_wr_en),
    .o_illegal_instr  (o_illegal_instr),
    .o_state          (o_state),
    .o_instret        (o_instret)
  );

  always #5 i_clk = ~i_clk;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7,
                 AW = 8, BR = 9, J = 10, JT = 11, TR = 12;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         IALU = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111;

  // Expected {req,wr,adr,ir,pc,src_a,src_b,op_class,result_sel,rf_wr} per state.
  function automatic logic [14:0] exp_vec(int st, logic rdy, logic z);
    logic req = 0, wr = 0, adr = 0, ir = 0, pc = 0, rf = 0;
    logic [1:0] a = 0, b = 0, op = 0, res = 0;
    case (st)
      F:   begin req = 1; b = 2'b10; res = 2'b10; ir = rdy; pc = rdy; end
      D:   begin a = 2'b01; b = 2'b01; end
      MA:  begin a = 2'b10; b = 2'b01; end
      MR:  begin req = 1; adr = 1; end
      MWB: begin res = 2'b01; rf = 1; end
      MW:  begin req = 1; wr = 1; adr = 1; end
      ER:  begin a = 2'b10; op = 2'b10; end
      EI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      AW:  rf = 1;
      BR:  begin a = 2'b10; op = 2'b01; pc = z; end
      J:   begin pc = 1; a = 2'b01; b = 2'b10; end
      JT:  begin a = 2'b10; b = 2'b01; end
      default: ;
    endcase
    return {req, wr, adr, ir, pc, a, b, op, res, rf};
  endfunction

  function automatic logic [31:0] exp_instret();
`ifdef MC_CTRL_INSTRET_EN
    return retired;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {mif.o_mem_req, mif.o_mem_wr_en, mif.o_adr_src, o_ir_wr_en, o_pc_wr_en,
            o_alu_src_a, o_alu_src_b, o_alu_op_class, o_result_sel, o_reg_file_wr_en};
  endfunction

  // One clock: drive inputs, check at the falling edge, advance past the rising edge.
  task automatic cyc(input int st, input logic rdy, input logic z, input logic ill);
    mif.i_mem_ready = rdy;
    i_alu_zero_flag = z;
    @(negedge i_clk);
    chk($sformatf("state(exp %0d)", st), 32'(o_state), 32'(st));
    chk($sformatf("outputs(state %0d)", st), 32'(dut_vec()), 32'(exp_vec(st, rdy, z)));
    chk("illegal", 32'(o_illegal_instr), 32'(ill));
    chk("instret", o_instret, exp_instret());
    @(posedge i_clk);
    #1;
  endtask

  task automatic mem_phase(input int st, input int waits, input logic z);
    for (int k = 0; k <= waits; k++) cyc(st, k == waits, z, 1'b0);
  endtask

  // Full instruction: FETCH and data phases stretched by the given wait counts.
  task automatic run_instr(input logic [6:0] opc, input logic z, input int wf, input int wm);
    int ph[$];
    i_op_code = opc;
    case (opc)
      LOAD:    ph = '{F, D, MA, MR, MWB};
      STORE:   ph = '{F, D, MA, MW};
      RTYPE:   ph = '{F, D, ER, AW};
      IALU:    ph = '{F, D, EI, AW};
      BEQ:     ph = '{F, D, BR};
      JAL:     ph = '{F, D, J, AW};
      JALR:    ph = '{F, D, JT, J, AW};
      default: ph = '{F, D};
    endcase
    foreach (ph[i]) begin
      if (ph[i] == F)                     mem_phase(F, wf, z);
      else if (ph[i] == MR || ph[i] == MW) mem_phase(ph[i], wm, z);
      else                                cyc(ph[i], 1'($urandom_range(0, 1)), z, 1'b0);
    end
    if (ph.size() > 2) retired++;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    mif.i_mem_ready = 1'b0;
    @(negedge i_clk);
    chk("reset outputs forced", 32'(dut_vec()), 32'd0);
    @(posedge i_clk);
    #1;
    retired = 0;
    @(negedge i_clk);
    chk("reset state", 32'(o_state), 32'(F));
    chk("reset outputs", 32'(dut_vec()), 32'd0);
    chk("reset illegal", 32'(o_illegal_instr), 32'd0);
    chk("reset instret", o_instret, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  logic [6:0] legal_ops [7] = '{LOAD, STORE, RTYPE, IALU, BEQ, JAL, JALR};

  initial begin
    mif.i_mem_ready = 1'b0;
    do_reset();

    run_instr(RTYPE, 1'b0, 0, 0);
    run_instr(LOAD, 1'b0, 3, 3);
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);
    run_instr(JALR, 1'b0, 0, 0);
    run_instr(JAL, 1'b1, 1, 0);
    run_instr(STORE, 1'b0, 0, 2);
    run_instr(IALU, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++)
      run_instr(legal_ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));

    // Unsupported opcode parks in TRAP with the sticky flag and no memory traffic.
    run_instr(7'b1111111, 1'b0, 0, 0);
    for (int n = 0; n < 20; n++) cyc(TR, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    do_reset();

    // Reset during a stalled store write abandons it.
    i_op_code = STORE;
    cyc(F, 1'b1, 1'b0, 1'b0);
    cyc(D, 1'b0, 1'b0, 1'b0);
    cyc(MA, 1'b0, 1'b0, 1'b0);
    cyc(MW, 1'b0, 1'b0, 1'b0);
    cyc(MW, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int n = 0; n < 3; n++) run_instr(RTYPE, 1'b0, 0, 0);
    @(negedge i_clk);
    chk("instret after 3 R-types", o_instret, exp_instret());
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
